// File: rtl/input_stream_node.sv
`default_nettype none
// =====================================================================
// Module   : input_stream_node (with input_stream_node_pkg)
// Brief    : 2-D strided OBI read engine feeding one CGRA input column
//            through a credit-limited show-ahead FIFO.
// Options  : INPUT_STREAM_NODE_PERF_EN adds stall / memory-wait counters.
// Revision : 1.0 - initial release
// =====================================================================

package input_stream_node_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module input_stream_node
    import input_stream_node_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int STRIDE_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [31:0]         base_addr_i,
    input  logic [CNT_W-1:0]    inner_cnt_i,
    input  logic [CNT_W-1:0]    outer_cnt_i,
    input  logic [STRIDE_W-1:0] inner_stride_i,
    input  logic [STRIDE_W-1:0] outer_stride_i,
    output obi_req_t            masters_req_o,
    input  obi_resp_t           masters_resp_i,
    output logic [31:0]         dout_o,
    output logic                dout_v_o,
    input  logic                dout_r_i,
    output logic                busy_o,
`ifdef INPUT_STREAM_NODE_PERF_EN
    output logic [31:0]         stall_cycles_o,
    output logic [31:0]         mem_wait_cycles_o,
`endif
    output logic                done_o
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;     // holds 0..FIFO_DEPTH
    localparam int c_DRP_W = c_CNT_W + 4;     // room for several stacked clears

    localparam logic [c_CNT_W:0]   c_DEPTH   = FIFO_DEPTH[c_CNT_W:0];
    localparam logic [CNT_W-1:0]   c_CNT_ONE = 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_OCC_ONE = 1;
    localparam logic [c_DRP_W-1:0] c_DRP_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_inner_cnt, r_outer_cnt, r_x, r_y;
    logic [STRIDE_W-1:0] r_inner_stride, r_outer_stride;
    logic [31:0]         r_row_addr, r_addr;
    logic                r_busy, r_done;
    logic [c_CNT_W-1:0]  r_outstanding;
    logic [c_DRP_W-1:0]  r_drop;
    logic [31:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr, r_rptr;
    logic [c_CNT_W-1:0]  r_count;

    // Credit: never have more reads in flight plus buffered than FIFO slots.
    wire  [c_CNT_W:0] w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
    wire              w_req         = (r_state == S_ISSUE) && (w_credit_used < c_DEPTH);
    wire              w_gnt         = w_req && masters_resp_i.gnt;
    wire              w_start       = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    wire              w_zero_cfg    = (inner_cnt_i == '0) || (outer_cnt_i == '0);
    wire              w_last_x      = (r_x == (r_inner_cnt - c_CNT_ONE));
    wire              w_last_y      = (r_y == (r_outer_cnt - c_CNT_ONE));
    wire  [31:0]      w_inner_step  = 32'(r_inner_stride);
    wire  [31:0]      w_next_row    = r_row_addr + 32'(r_outer_stride);

    // Responses owed for requests granted before a clear are discarded first.
    wire              w_rsp_drop    = masters_resp_i.rvalid && (r_drop != '0);
    wire              w_rsp_take    = masters_resp_i.rvalid && (r_drop == '0) && (r_outstanding != '0);
    wire              w_push        = w_rsp_take;
    wire              w_pop         = dout_v_o && dout_r_i;
    wire  [c_DRP_W-1:0] w_in_flight = c_DRP_W'(r_outstanding) + c_DRP_W'(w_gnt) - c_DRP_W'(w_rsp_take);
    wire  [c_DRP_W-1:0] w_drop_clr  = r_drop - c_DRP_W'(w_rsp_drop) + w_in_flight;

    // Control FSM with address generator and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;  r_busy <= 1'b0;  r_done <= 1'b0;
            r_inner_cnt <= '0;  r_outer_cnt <= '0;
            r_inner_stride <= '0;  r_outer_stride <= '0;
            r_x <= '0;  r_y <= '0;  r_row_addr <= '0;  r_addr <= '0;
        end else if (clear_i) begin
            r_state <= S_IDLE;  r_busy <= 1'b0;  r_done <= 1'b0;
            r_inner_cnt <= '0;  r_outer_cnt <= '0;
            r_inner_stride <= '0;  r_outer_stride <= '0;
            r_x <= '0;  r_y <= '0;  r_row_addr <= '0;  r_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_inner_cnt    <= inner_cnt_i;
                        r_outer_cnt    <= outer_cnt_i;
                        r_inner_stride <= inner_stride_i;
                        r_outer_stride <= outer_stride_i;
                        r_x            <= '0;
                        r_y            <= '0;
                        r_row_addr     <= base_addr_i;
                        r_addr         <= base_addr_i;
                        if (w_zero_cfg) begin
                            r_state <= S_DONE;  r_busy <= 1'b0;  r_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE; r_busy <= 1'b1;  r_done <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_gnt) begin
                        if (w_last_x) begin
                            r_x        <= '0;
                            r_row_addr <= w_next_row;
                            r_addr     <= w_next_row;
                            if (w_last_y) r_state <= S_DRAIN;
                            else          r_y     <= r_y + c_CNT_ONE;
                        end else begin
                            r_x    <= r_x + c_CNT_ONE;
                            r_addr <= r_addr + w_inner_step;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((r_outstanding == '0) && (r_count == '0)) begin
                        r_state <= S_DONE;  r_busy <= 1'b0;  r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outstanding-read and discard-on-arrival bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (clear_i) begin
            r_outstanding <= '0;
            r_drop        <= w_drop_clr;
        end else begin
            case ({w_gnt, w_rsp_take})
                2'b10:   r_outstanding <= r_outstanding + c_OCC_ONE;
                2'b01:   r_outstanding <= r_outstanding - c_OCC_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_rsp_drop) r_drop <= r_drop - c_DRP_ONE;
        end
    end

    // FIFO storage; contents need no reset because the head is gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= masters_resp_i.rdata;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;  r_rptr <= '0;  r_count <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;  r_rptr <= '0;  r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_OCC_ONE;
                2'b01:   r_count <= r_count - c_OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef INPUT_STREAM_NODE_PERF_EN
    logic [31:0] r_stall_cycles, r_mem_wait_cycles;

    // Saturating performance counters, restarted by every accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cycles    <= '0;
            r_mem_wait_cycles <= '0;
        end else if (clear_i || w_start) begin
            r_stall_cycles    <= '0;
            r_mem_wait_cycles <= '0;
        end else begin
            if (dout_v_o && !dout_r_i && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_req && !masters_resp_i.gnt && (r_mem_wait_cycles != 32'hFFFF_FFFF))
                r_mem_wait_cycles <= r_mem_wait_cycles + 32'd1;
        end
    end

    assign stall_cycles_o    = r_stall_cycles;
    assign mem_wait_cycles_o = r_mem_wait_cycles;
`else
    // Performance counters are not built in this configuration.
`endif

    assign masters_req_o.req   = w_req;
    assign masters_req_o.we    = 1'b0;
    assign masters_req_o.be    = 4'hF;
    assign masters_req_o.addr  = r_addr;
    assign masters_req_o.wdata = 32'd0;

    assign dout_v_o = (r_count != '0);
    assign dout_o   = dout_v_o ? r_mem[r_rptr] : 32'd0;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_input_stream_node.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : tb_input_stream_node
// Brief    : Self-checking bench for input_stream_node with an OBI memory
//            responder, a stream sink and a nested-loop address model.
// Options  : INPUT_STREAM_NODE_PERF_EN enables the counter scenario.
// Revision : 1.0 - initial release
// =====================================================================
module tb_input_stream_node;
    import input_stream_node_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] inner_cnt = '0, outer_cnt = '0, inner_stride = '0, outer_stride = '0;
    obi_req_t    mreq;
    obi_resp_t   mresp;
    logic [31:0] dout;
    logic        dout_v, dout_r, busy, done;
`ifdef INPUT_STREAM_NODE_PERF_EN
    logic [31:0] stall_cycles, mem_wait_cycles;
`endif

    input_stream_node #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(16), .STRIDE_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
        .base_addr_i(base_addr), .inner_cnt_i(inner_cnt), .outer_cnt_i(outer_cnt),
        .inner_stride_i(inner_stride), .outer_stride_i(outer_stride),
        .masters_req_o(mreq), .masters_resp_i(mresp),
        .dout_o(dout), .dout_v_o(dout_v), .dout_r_i(dout_r), .busy_o(busy),
`ifdef INPUT_STREAM_NODE_PERF_EN
        .stall_cycles_o(stall_cycles), .mem_wait_cycles_o(mem_wait_cycles),
`endif
        .done_o(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Agent controls and observations
    int  gnt_mode = 0;       // <0: random 0..2 wait cycles per request, else fixed
    int  rlat_mode = 1;      // <0: random 1..3 cycles gnt->rvalid, else fixed
    int  ready_mode = 0;     // 0 high, 1 random, 2 low, 3 low for stall_left valid cycles
    int  stall_left = 0;
    int  grant_cnt = 0, pop_cnt = 0;
    bit  credit_bad = 0, hold_bad = 0, req_seen = 0;
    logic [31:0] grant_log[$], data_log[$], exp_addr[$], exp_data[$];

    typedef struct { logic [31:0] data; longint due; } rsp_t;
    rsp_t rsp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ a ^ 32'hC3A5_5A3C;
    endfunction

    function automatic int pick_gnt();
        return (gnt_mode < 0) ? int'($urandom_range(0, 2)) : gnt_mode;
    endfunction

    function automatic int pick_lat();
        return (rlat_mode < 0) ? int'($urandom_range(1, 3)) : rlat_mode;
    endfunction

    // OBI memory responder and stream sink, both acting on the falling edge.
    initial begin
        longint cyc = 0, last_due = 0, due;
        int     wait_cnt = 0, cur_delay = 0;
        bit     prev_wait = 0, r;
        logic [31:0] prev_addr = '0;
        mresp = '0;
        dout_r = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rsp_q.delete();
                mresp = '0;
                wait_cnt = 0;
                prev_wait = 0;
            end else begin
                if (prev_wait && !clear && (!mreq.req || mreq.addr !== prev_addr)) hold_bad = 1;
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    mresp.rvalid = 1'b1;
                    mresp.rdata  = rsp_q[0].data;
                    void'(rsp_q.pop_front());
                end else begin
                    mresp.rvalid = 1'b0;
                    mresp.rdata  = $urandom;
                end
                if (mreq.req) begin
                    req_seen = 1;
                    if (wait_cnt >= cur_delay) begin
                        mresp.gnt = 1'b1;
                        grant_log.push_back(mreq.addr);
                        grant_cnt++;
                        due = cyc + longint'(pick_lat());
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        rsp_q.push_back('{data: mem_word(mreq.addr), due: due});
                        wait_cnt = 0;
                        cur_delay = pick_gnt();
                    end else begin
                        mresp.gnt = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    mresp.gnt = 1'b0;
                    wait_cnt = 0;
                    cur_delay = pick_gnt();
                end
                prev_wait = mreq.req && !mresp.gnt;
                prev_addr = mreq.addr;
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                2:       r = 1'b0;
                default: begin
                    r = 1'b1;
                    if (dout_v && stall_left > 0) begin r = 1'b0; stall_left--; end
                end
            endcase
            dout_r = r;
            if (dout_v && r) begin
                data_log.push_back(dout);
                pop_cnt++;
            end
            if (grant_cnt - pop_cnt > FIFO_DEPTH) credit_bad = 1;
        end
    end

    // Reference model: every element address straight from the 2-D loop formula.
    task automatic build_expected(input logic [31:0] b, input int ic, input int oc,
                                  input logic [15:0] is, input logic [15:0] os);
        logic [31:0] a;
        exp_addr.delete();
        exp_data.delete();
        for (int y = 0; y < oc; y++)
            for (int x = 0; x < ic; x++) begin
                a = b + 32'(y) * 32'(os) + 32'(x) * 32'(is);
                exp_addr.push_back(a);
                exp_data.push_back(mem_word(a));
            end
    endtask

    task automatic start_transfer(input logic [31:0] b, input int ic, input int oc,
                                  input logic [15:0] is, input logic [15:0] os);
        build_expected(b, ic, oc, is, os);
        @(negedge clk); #1;
        grant_log.delete(); data_log.delete();
        grant_cnt = 0; pop_cnt = 0; credit_bad = 0; hold_bad = 0; req_seen = 0;
        base_addr = b; inner_cnt = 16'(ic); outer_cnt = 16'(oc);
        inner_stride = is; outer_stride = os;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin timed_out = 0; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (mreq.req !== 1'b0)  begin n_err++; $display("FAIL reset_req: got %b want 0", mreq.req); end
        n_cmp++; if (mreq.addr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mreq.addr); end
        n_cmp++; if (dout_v !== 1'b0)    begin n_err++; $display("FAIL reset_dout_v: got %b want 0", dout_v); end
        n_cmp++; if (dout !== 32'd0)     begin n_err++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pattern(input string nm, input logic [31:0] b, input int ic, input int oc,
                                input logic [15:0] is, input logic [15:0] os);
        bit to;
        start_transfer(b, ic, oc, is, os);
        wait_done(to);
        n_cmp++; if (to) begin n_err++; $display("FAIL %s_timeout: done never rose", nm); end
        n_cmp++; if (grant_log.size() != exp_addr.size()) begin n_err++; $display("FAIL %s_ngrant: got %0d want %0d", nm, grant_log.size(), exp_addr.size()); end
        n_cmp++; if (data_log.size() != exp_data.size()) begin n_err++; $display("FAIL %s_nword: got %0d want %0d", nm, data_log.size(), exp_data.size()); end
        foreach (exp_addr[i]) begin
            if (i < grant_log.size()) begin
                n_cmp++; if (grant_log[i] !== exp_addr[i]) begin n_err++; $display("FAIL %s_addr[%0d]: got %h want %h", nm, i, grant_log[i], exp_addr[i]); end
            end
            if (i < data_log.size()) begin
                n_cmp++; if (data_log[i] !== exp_data[i]) begin n_err++; $display("FAIL %s_data[%0d]: got %h want %h", nm, i, data_log[i], exp_data[i]); end
            end
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL %s_status: got done=%b busy=%b want done=1 busy=0", nm, done, busy); end
        n_cmp++; if (rsp_q.size() != 0) begin n_err++; $display("FAIL %s_outstanding: got %0d pending want 0", nm, rsp_q.size()); end
        n_cmp++; if (credit_bad || hold_bad) begin n_err++; $display("FAIL %s_protocol: got credit_bad=%0d hold_bad=%0d want 0/0", nm, credit_bad, hold_bad); end
    endtask

    task automatic test_single_row();
        gnt_mode = 0; rlat_mode = 1; ready_mode = 0;
        test_pattern("row", 32'h1000, 4, 1, 16'd4, 16'd0);
    endtask

    task automatic test_two_rows();
        gnt_mode = 0; rlat_mode = 1; ready_mode = 0;
        test_pattern("rows2", 32'h2000, 3, 2, 16'd8, 16'h100);
    endtask

    task automatic test_backpressure();
        bit to;
        gnt_mode = 0; rlat_mode = 1; ready_mode = 2;
        start_transfer(32'h0004_0000 | ($urandom & 32'hFFFC), 8, 1, 16'd4, 16'd0);
        repeat (20) begin @(negedge clk); #1; end
        n_cmp++; if (grant_cnt != FIFO_DEPTH) begin n_err++; $display("FAIL bp_grants: got %0d want %0d", grant_cnt, FIFO_DEPTH); end
        n_cmp++; if (mreq.req !== 1'b0) begin n_err++; $display("FAIL bp_req_held: got %b want 0", mreq.req); end
        n_cmp++; if (dout_v !== 1'b1 || dout !== exp_data[0]) begin n_err++; $display("FAIL bp_head: got v=%b %h want v=1 %h", dout_v, dout, exp_data[0]); end
        ready_mode = 0;
        wait_done(to);
        n_cmp++; if (to) begin n_err++; $display("FAIL bp_timeout: done never rose"); end
        n_cmp++; if (data_log.size() != 8) begin n_err++; $display("FAIL bp_nword: got %0d want 8", data_log.size()); end
        foreach (exp_data[i]) if (i < data_log.size()) begin
            n_cmp++; if (data_log[i] !== exp_data[i]) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, data_log[i], exp_data[i]); end
        end
        n_cmp++; if (credit_bad) begin n_err++; $display("FAIL bp_credit: got overflow want none"); end
    endtask

    task automatic test_zero_count();
        for (int k = 0; k < 2; k++) begin
            gnt_mode = 0; rlat_mode = 1; ready_mode = 0;
            if (k == 0) start_transfer(32'h3000, 0, 3, 16'd4, 16'd4);
            else        start_transfer(32'h3000, 2, 0, 16'd4, 16'd4);
            n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero%0d_done: got done=%b busy=%b want 1/0", k, done, busy); end
            repeat (5) begin @(negedge clk); #1; end
            n_cmp++; if (req_seen || grant_cnt != 0) begin n_err++; $display("FAIL zero%0d_req: got req_seen=%0d grants=%0d want 0/0", k, req_seen, grant_cnt); end
        end
    endtask

    task automatic test_clear();
        gnt_mode = 2; rlat_mode = 4; ready_mode = 1;
        start_transfer(32'h5000, 8, 1, 16'd4, 16'd0);
        for (int i = 0; i < 200 && grant_cnt < 2; i++) begin @(negedge clk); #1; end
        n_cmp++; if (grant_cnt != 2) begin n_err++; $display("FAIL clr_reach: got %0d grants want 2", grant_cnt); end
        clear = 1'b1;
        @(negedge clk); #1;
        clear = 1'b0;
        n_cmp++; if (busy !== 1'b0 || dout_v !== 1'b0 || done !== 1'b0 || mreq.req !== 1'b0) begin
            n_err++; $display("FAIL clr_idle: got busy=%b v=%b done=%b req=%b want 0/0/0/0", busy, dout_v, done, mreq.req);
        end
        gnt_mode = -1; rlat_mode = -1;
        test_pattern("after_clr", 32'h6000 | ($urandom & 32'h0FFC), 3, 2, 16'd12, 16'h40);
    endtask

    task automatic test_random();
        logic [31:0] b;
        logic [15:0] is, os;
        for (int k = 0; k < 6; k++) begin
            gnt_mode = -1; rlat_mode = -1; ready_mode = 1;
            b  = (k == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            is = (k == 0) ? 16'd8  : 16'($urandom & 32'hFFFC);
            os = (k == 0) ? 16'h40 : 16'($urandom & 32'hFFFC);
            test_pattern($sformatf("rnd%0d", k), b, int'($urandom_range(1, 5)), int'($urandom_range(1, 3)), is, os);
        end
    endtask

`ifdef INPUT_STREAM_NODE_PERF_EN
    task automatic test_perf();
        bit to;
        gnt_mode = 3; rlat_mode = 1; ready_mode = 3; stall_left = 5;
        start_transfer(32'h7000, 4, 1, 16'd4, 16'd0);
        wait_done(to);
        n_cmp++; if (to) begin n_err++; $display("FAIL perf_timeout: done never rose"); end
        n_cmp++; if (mem_wait_cycles !== 32'd12) begin n_err++; $display("FAIL perf_mem_wait: got %0d want 12", mem_wait_cycles); end
        n_cmp++; if (stall_cycles !== 32'd5) begin n_err++; $display("FAIL perf_stall: got %0d want 5", stall_cycles); end
        n_cmp++; if (data_log.size() != 4) begin n_err++; $display("FAIL perf_nword: got %0d want 4", data_log.size()); end
        ready_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_row();
        test_two_rows();
        test_backpressure();
        test_zero_count();
        test_clear();
        test_random();
`ifdef INPUT_STREAM_NODE_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/input_stream_node.md
Name: input_stream_node

Overview:
Parametrised successor to the single-stride input memory node, feeding one CGRA input column.
- Generates a 2-D strided address pattern (inner count/stride, outer count/stride).
- Fetches words over one OBI master port and buffers read data in a credit-limited FIFO.
- Streams words to the CGRA core with a valid/ready handshake.
- Multiple instances are placed by the top level, one per input node.

Parameters:
FIFO_DEPTH, 4, read-data buffer entries; power of 2, >=2; also the maximum number of outstanding OBI reads.
CNT_W, 16, width of the inner/outer count registers.
STRIDE_W, 16, width of the inner/outer byte-stride registers (unsigned).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear: return to IDLE, flush FIFO, reset counters
start_i  in  1  single-cycle pulse; latches configuration and begins a transfer
base_addr_i  in  32  byte address of first word (word-aligned)
inner_cnt_i  in  CNT_W  words per row
outer_cnt_i  in  CNT_W  number of rows
inner_stride_i  in  STRIDE_W  byte step between words in a row
outer_stride_i  in  STRIDE_W  byte step between row starts
masters_req_o  out  obi_req_t  OBI request (req, we=0, be=4'hF, addr, wdata=0)
masters_resp_i  in  obi_resp_t  OBI response (gnt, rvalid, rdata)
dout_o  out  32  stream data
dout_v_o  out  1  stream valid
dout_r_i  in  1  stream ready
busy_o  out  1  high from accepted start until DONE
done_o  out  1  high in DONE until next start/clear

Behaviour:
- Reset: req=0, addr=0, dout_v_o=0, dout_o=0, busy_o=0, done_o=0; FSM in IDLE; FIFO empty; outstanding=0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start_i latches all config inputs.
  - If inner_cnt or outer_cnt is 0: go to DONE; no OBI traffic.
  - Otherwise: go to ISSUE.
  - start_i is ignored outside IDLE and DONE. In DONE, start_i restarts exactly as from IDLE.
- ISSUE: req=1 when outstanding + fifo_count < FIFO_DEPTH.
  - addr = row_addr + x*inner_stride, computed incrementally; 32-bit wrap, no overflow flag.
  - req/addr hold stable until gnt; no address change while req=1 and gnt=0.
  - On gnt: x++. When x reaches inner_cnt: x=0, y++, row_addr += outer_stride.
  - After the final element is granted: go to DRAIN.
- DRAIN: wait until outstanding=0 and FIFO empty, then go to DONE.
- DONE: done_o=1, busy_o=0.
- Outstanding counter: +1 on gnt, -1 on rvalid; simultaneous gnt and rvalid leave it unchanged.
- On rvalid, rdata is pushed into the FIFO. The credit rule guarantees the FIFO never overflows; the bench asserts this.
- Stream side: dout_o/dout_v_o come from the FIFO head (show-ahead). Pop on dout_v_o & dout_r_i.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot).
  - First word latency: rvalid at cycle N -> dout_v_o=1 at N+1.
- clear_i: same effect as reset except it is synchronous. Mid-transfer, any rvalid still in flight afterwards is dropped.
  - Clearing with outstanding>0 is legal but requires the memory to keep rvalid; the node ignores it.
- Data is never reordered; OBI responses are assumed in-order per port.

Optional Feature:
Macro: INPUT_STREAM_NODE_PERF_EN.
- Defined: adds output ports stall_cycles_o[31:0] and mem_wait_cycles_o[31:0].
  - stall_cycles_o counts cycles with dout_v_o & !dout_r_i.
  - mem_wait_cycles_o counts cycles with req & !gnt.
  - Both clear on start_i, clear_i or reset, and saturate at 32'hFFFF_FFFF.
- Not defined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Base 0x1000, inner 4/stride 4, outer 1, ready tied high, gnt/rvalid one cycle later -> addrs 0x1000,0x1004,0x1008,0x100C; 4 words out in order; done_o=1; outstanding=0.
- Base 0x2000, inner 3/stride 8, outer 2/stride 0x100 -> addrs 0x2000,0x2008,0x2010,0x2100,0x2108,0x2110.
- FIFO_DEPTH=4, dout_r_i=0 for 20 cycles -> exactly 4 grants issued; no 5th req until a pop; no data lost after ready rises.
- inner_cnt=0 -> DONE within 1 cycle of start; req never asserted.
- clear_i asserted after 2 of 8 grants -> IDLE next cycle, dout_v_o=0, busy_o=0; fresh start completes correctly.
- With INPUT_STREAM_NODE_PERF_EN: gnt delayed 3 cycles per request for 4 requests, ready held low 5 cycles -> mem_wait_cycles_o=12, stall_cycles_o=5.
